// File: rtl/riscpipe_pkg.sv
// Shared definitions for the 4-stage pipeline hazard controller.
//   - Opcode constants OP_NOP..OP_BR
//   - Forwarding-select encodings FWD_RF / FWD_MEM / FWD_WB
//   - shadow_t: one entry of the EX/MEM/WB shadow pipe {valid, op, rd}
//   - writes_reg(): opcode produces a register-file result
//   - fwd_sel(): priority encode of EX/MEM producer hits into a forward select
package riscpipe_pkg;

    localparam int unsigned SH_OP_W = 4;
    localparam int unsigned SH_RD_W = 2;

    localparam logic [SH_OP_W-1:0] OP_NOP   = 4'd0;
    localparam logic [SH_OP_W-1:0] OP_ADD   = 4'd1;
    localparam logic [SH_OP_W-1:0] OP_SUB   = 4'd2;
    localparam logic [SH_OP_W-1:0] OP_AND   = 4'd3;
    localparam logic [SH_OP_W-1:0] OP_OR    = 4'd4;
    localparam logic [SH_OP_W-1:0] OP_LOADI = 4'd5;
    localparam logic [SH_OP_W-1:0] OP_LOAD  = 4'd6;
    localparam logic [SH_OP_W-1:0] OP_STORE = 4'd7;
    localparam logic [SH_OP_W-1:0] OP_BR    = 4'd8;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic               valid;
        logic [SH_OP_W-1:0] op;
        logic [SH_RD_W-1:0] rd;
    } shadow_t;

    function automatic logic writes_reg(input logic [SH_OP_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_LOAD);
    endfunction

    // The producer currently in EX is one cycle from MEM, so its result comes from the
    // MEM-stage bus next cycle; a producer in MEM will be on the WB bus next cycle.
    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
        if (ex_hit) begin
            return FWD_MEM;
        end else if (mem_hit) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hz_match.sv
// RAW hazard detector for one (ID source operand, in-flight stage) pair.
// Ports:
//   src_use_i  - ID instruction actually reads this source
//   id_valid_i - ID holds a real instruction
//   src_i      - ID source register address
//   stg_valid_i, stg_op_i, stg_rd_i - shadow entry of the stage being compared
//   match_o    - stage will write the register the ID instruction reads
module hz_match
    import riscpipe_pkg::*;
(
    input  logic               src_use_i,
    input  logic               id_valid_i,
    input  logic [SH_RD_W-1:0] src_i,
    input  logic               stg_valid_i,
    input  logic [SH_OP_W-1:0] stg_op_i,
    input  logic [SH_RD_W-1:0] stg_rd_i,
    output logic               match_o
);

    assign match_o = src_use_i & id_valid_i & stg_valid_i & writes_reg(stg_op_i)
                     & (stg_rd_i == src_i);

endmodule

// File: rtl/wb_hazard_ctrl.sv
// Pipeline controller for the ID->EX->MEM->WB datapath.
// Tracks a shadow pipe {valid, op, rd} for EX/MEM/WB, drives write-back controls, detects
// RAW hazards against in-flight writers and (optionally) drives EX operand forward selects.
// Build option: define WB_HAZARD_FWD_EN to enable forwarding; stalls then occur only on
// load-use. Without it, ex_fwd_a/b are tied to register-file and any EX/MEM hit stalls.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   id_valid/opcode/rd/rs1/rs2 - instruction in ID
//   id_rs_use                  - [0] rs1 read, [1] rs2 read
//   flush                      - kill the instruction entering EX
//   stall                      - combinational; hold IF/ID and bubble EX
//   ex_fwd_a, ex_fwd_b         - registered EX operand source selects
//   wb_sel, wb_we, wb_rd, wb_opcode - write-back controls
module wb_hazard_ctrl
    import riscpipe_pkg::*;
#(
    parameter int unsigned OP_W   = 4,
    parameter int unsigned REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [OP_W-1:0]   id_opcode,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [1:0]        id_rs_use,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        ex_fwd_a,
    output logic [1:0]        ex_fwd_b,
    output logic              wb_sel,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_rd,
    output logic [OP_W-1:0]   wb_opcode
);

    shadow_t ex_q, ex_d;
    shadow_t mem_q, mem_d;
    shadow_t wb_q, wb_d;

    logic m_a_ex, m_a_mem, m_b_ex, m_b_mem;
    logic advance;

    // WB-stage writers are never compared: the register file is write-first.
    hz_match u_match_a_ex (
        .src_use_i   (id_rs_use[0]),
        .id_valid_i  (id_valid),
        .src_i       (id_rs1),
        .stg_valid_i (ex_q.valid),
        .stg_op_i    (ex_q.op),
        .stg_rd_i    (ex_q.rd),
        .match_o     (m_a_ex)
    );

    hz_match u_match_a_mem (
        .src_use_i   (id_rs_use[0]),
        .id_valid_i  (id_valid),
        .src_i       (id_rs1),
        .stg_valid_i (mem_q.valid),
        .stg_op_i    (mem_q.op),
        .stg_rd_i    (mem_q.rd),
        .match_o     (m_a_mem)
    );

    hz_match u_match_b_ex (
        .src_use_i   (id_rs_use[1]),
        .id_valid_i  (id_valid),
        .src_i       (id_rs2),
        .stg_valid_i (ex_q.valid),
        .stg_op_i    (ex_q.op),
        .stg_rd_i    (ex_q.rd),
        .match_o     (m_b_ex)
    );

    hz_match u_match_b_mem (
        .src_use_i   (id_rs_use[1]),
        .id_valid_i  (id_valid),
        .src_i       (id_rs2),
        .stg_valid_i (mem_q.valid),
        .stg_op_i    (mem_q.op),
        .stg_rd_i    (mem_q.rd),
        .match_o     (m_b_mem)
    );

`ifdef WB_HAZARD_FWD_EN
    // A LOAD in EX has no result until WB, so its consumer waits one cycle and then
    // picks the value up from the WB bus via the MEM-stage hit.
    logic load_in_ex;
    assign load_in_ex = ex_q.valid & (ex_q.op == OP_LOAD);
    assign stall      = (m_a_ex | m_b_ex) & load_in_ex;
`else
    assign stall = m_a_ex | m_a_mem | m_b_ex | m_b_mem;
`endif

    // flush wins over stall for EX; stall alone still holds ID upstream.
    assign advance = id_valid & ~stall & ~flush;

    always_comb begin
        ex_d = '0;
        if (advance) begin
            ex_d.valid = 1'b1;
            ex_d.op    = id_opcode;
            ex_d.rd    = id_rd;
        end
        mem_d = ex_q;
        wb_d  = mem_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

`ifdef WB_HAZARD_FWD_EN
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;

    // Selects travel with the instruction into EX; a bubble always reads the regfile.
    always_comb begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (advance) begin
            fwd_a_d = fwd_sel(m_a_ex, m_a_mem);
            fwd_b_d = fwd_sel(m_b_ex, m_b_mem);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign ex_fwd_a = fwd_a_q;
    assign ex_fwd_b = fwd_b_q;
`else
    assign ex_fwd_a = FWD_RF;
    assign ex_fwd_b = FWD_RF;
`endif

    // Gate with valid so a bubble in WB presents all-zero controls.
    always_comb begin
        wb_we     = wb_q.valid & writes_reg(wb_q.op);
        wb_sel    = wb_q.valid & (wb_q.op != OP_LOADI);
        wb_rd     = wb_q.valid ? wb_q.rd : '0;
        wb_opcode = wb_q.valid ? wb_q.op : '0;
    end

endmodule
